stack_sequencer: RTL and testbench

- Upstream control stage for the stack-pointer/stack-RAM block of the TTM4 emulator.
- Converts single-cycle PUSH/POP requests from the instruction decoder into the stack block's control sequence: counter enable, up/down direction, count clock and store-bus drive.
- Tracks stack occupancy, flags overflow and underflow, and returns popped nibbles to the datapath.

---
 rtl/stack_pkg.sv | 36 +++
 rtl/stack_sequencer_if.sv | 36 +++
 rtl/stack_depth_counter.sv | 45 ++++
 rtl/stack_sequencer.sv | 170 +++++++++++++++++
 tb/tb_stack_sequencer.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/stack_pkg.sv
// Shared types and constants for the stack sequencer.
//   state_e      : sequencer FSM states
//   DIR_PUSH/POP : SP_D_nU encodings
//   stack_ctrl_t : stack-block control bundle, CTRL_RST is its reset/idle value
package stack_pkg;

  localparam int unsigned NIBBLE_W = 4;
  localparam int unsigned DEPTH_W  = 9;
  localparam int unsigned SETTLE_W = 3;

  typedef enum logic [3:0] {
    IDLE,
    P_SETUP,
    P_WRITE,
    P_COUNT,
    P_REL,
    Q_SETUP,
    Q_COUNT,
    Q_SETTLE,
    Q_READ,
    FIN
  } state_e;

  localparam logic DIR_PUSH = 1'b0;
  localparam logic DIR_POP  = 1'b1;

  typedef struct packed {
    logic nsk_en;
    logic sp_d_nu;
    logic spc;
    logic store_oe;
  } stack_ctrl_t;

  localparam stack_ctrl_t CTRL_RST = '{nsk_en: 1'b1, sp_d_nu: DIR_POP, spc: 1'b0, store_oe: 1'b0};

endpackage

// File: rtl/stack_sequencer_if.sv
// Request/response and store-bus signals of the stack sequencer.
//   master : decoder + stack block side (drives requests, DIN, STORE_DI)
//   slave  : stack_sequencer side (drives status, DOUT and stack controls)
interface stack_sequencer_if;
  import stack_pkg::*;

  logic                PUSH_REQ;
  logic                POP_REQ;
  logic [NIBBLE_W-1:0] DIN;
  logic                BUSY;
  logic                DONE;
  logic [NIBBLE_W-1:0] DOUT;
  logic                OVF;
  logic                UNF;
  logic                REQ_ERR;
  logic [DEPTH_W-1:0]  DEPTH;
  logic                nSK_EN;
  logic                SP_D_nU;
  logic                SPC;
  logic                STORE_OE;
  logic [NIBBLE_W-1:0] STORE_DO;
  logic [NIBBLE_W-1:0] STORE_DI;

  modport master (
    output PUSH_REQ, POP_REQ, DIN, STORE_DI,
    input  BUSY, DONE, DOUT, OVF, UNF, REQ_ERR, DEPTH,
    input  nSK_EN, SP_D_nU, SPC, STORE_OE, STORE_DO
  );

  modport slave (
    input  PUSH_REQ, POP_REQ, DIN, STORE_DI,
    output BUSY, DONE, DOUT, OVF, UNF, REQ_ERR, DEPTH,
    output nSK_EN, SP_D_nU, SPC, STORE_OE, STORE_DO
  );

endinterface

// File: rtl/stack_depth_counter.sv
// Stack occupancy counter with full/empty compare.
//   clk, rst      : clock, synchronous active-high reset
//   inc, dec      : count up/down by one (guarded by full/empty)
//   depth         : registered occupancy 0..DEPTH_MAX
//   full_c/empty_c: decoded from the depth register
module stack_depth_counter
  import stack_pkg::*;
#(
  parameter int unsigned DEPTH_MAX = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  input  logic               dec,
  output logic [DEPTH_W-1:0] depth,
  output logic               full_c,
  output logic               empty_c
);

  logic [DEPTH_W-1:0] depth_q;
  logic [DEPTH_W-1:0] depth_d;

  assign full_c  = (depth_q == DEPTH_W'(DEPTH_MAX));
  assign empty_c = (depth_q == '0);
  assign depth   = depth_q;

  // Guarded so the count never wraps past either end.
  always_comb begin
    depth_d = depth_q;
    if (inc && !full_c) begin
      depth_d = depth_q + DEPTH_W'(1);
    end else if (dec && !empty_c) begin
      depth_d = depth_q - DEPTH_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      depth_q <= '0;
    end else begin
      depth_q <= depth_d;
    end
  end

endmodule

// File: rtl/stack_sequencer.sv
// Turns single-cycle PUSH/POP requests into the stack block's control
// sequence (nSK_EN, SP_D_nU, SPC, STORE_OE/STORE_DO), tracks occupancy,
// flags overflow/underflow/conflicting requests and returns popped nibbles.
//   CLK, RST : clock, synchronous active-high reset
//   bus      : stack_sequencer_if.slave (requests, status, store bus)
module stack_sequencer
  import stack_pkg::*;
#(
  parameter int unsigned DEPTH_MAX  = 256,
  parameter int unsigned SETTLE_CYC = 1
) (
  input logic              CLK,
  input logic              RST,
  stack_sequencer_if.slave bus
);

  state_e              state_q, state_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  stack_ctrl_t         ctrl_q, ctrl_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic                req_err_q, req_err_d;
  logic [NIBBLE_W-1:0] dout_q, dout_d;
  logic [NIBBLE_W-1:0] store_do_q, store_do_d;

  logic idle_c;
  logic req_both_c;
  logic push_ok_c, push_rej_c;
  logic pop_ok_c, pop_rej_c;
  logic full_c, empty_c;
  logic depth_inc, depth_dec;
  logic [DEPTH_W-1:0] depth;

  // FIN is also a request-accepting state so back-to-back requests lose no cycle.
  assign idle_c     = (state_q == IDLE) || (state_q == FIN);
  assign req_both_c = idle_c && bus.PUSH_REQ && bus.POP_REQ;
  assign push_ok_c  = idle_c && bus.PUSH_REQ && !bus.POP_REQ && !full_c;
  assign push_rej_c = idle_c && bus.PUSH_REQ && !bus.POP_REQ && full_c;
  assign pop_ok_c   = idle_c && bus.POP_REQ && !bus.PUSH_REQ && !empty_c;
  assign pop_rej_c  = idle_c && bus.POP_REQ && !bus.PUSH_REQ && empty_c;

  // Occupancy moves at the end of the release/read cycle of a sequence.
  assign depth_inc = (state_q == P_REL);
  assign depth_dec = (state_q == Q_READ);

  stack_depth_counter #(
    .DEPTH_MAX (DEPTH_MAX)
  ) u_depth (
    .clk     (CLK),
    .rst     (RST),
    .inc     (depth_inc),
    .dec     (depth_dec),
    .depth   (depth),
    .full_c  (full_c),
    .empty_c (empty_c)
  );

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      settle_q   <= '0;
      ctrl_q     <= CTRL_RST;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      req_err_q  <= 1'b0;
      dout_q     <= '0;
      store_do_q <= '0;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      ctrl_q     <= ctrl_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      req_err_q  <= req_err_d;
      dout_q     <= dout_d;
      store_do_q <= store_do_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    case (state_q)
      IDLE, FIN: begin
        if (push_ok_c) begin
          state_d = P_SETUP;
        end else if (pop_ok_c) begin
          state_d = Q_SETUP;
        end else if (req_both_c || push_rej_c || pop_rej_c) begin
          state_d = FIN;
        end else begin
          state_d = IDLE;
        end
      end
      P_SETUP: state_d = P_WRITE;
      P_WRITE: state_d = P_COUNT;
      P_COUNT: state_d = P_REL;
      P_REL:   state_d = FIN;
      Q_SETUP: state_d = Q_COUNT;
      Q_COUNT: begin
        state_d  = Q_SETTLE;
        settle_d = SETTLE_W'(SETTLE_CYC - 1);
      end
      Q_SETTLE: begin
        if (settle_q == '0) begin
          state_d = Q_READ;
        end else begin
          settle_d = settle_q - SETTLE_W'(1);
        end
      end
      Q_READ:  state_d = FIN;
      default: state_d = IDLE;
    endcase
  end

  // Output logic, decoded from the next state so every output is a flop.
  always_comb begin
    ctrl_d     = CTRL_RST;
    busy_d     = 1'b1;
    done_d     = 1'b0;
    ovf_d      = push_rej_c;
    unf_d      = pop_rej_c;
    req_err_d  = req_both_c;
    dout_d     = (state_q == Q_READ) ? bus.STORE_DI : dout_q;
    store_do_d = push_ok_c ? bus.DIN : store_do_q;
    case (state_d)
      IDLE: busy_d = 1'b0;
      FIN: begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
      P_SETUP, P_WRITE:
        ctrl_d = '{nsk_en: 1'b0, sp_d_nu: DIR_PUSH, spc: 1'b0, store_oe: 1'b1};
      P_COUNT:
        ctrl_d = '{nsk_en: 1'b0, sp_d_nu: DIR_PUSH, spc: 1'b1, store_oe: 1'b1};
      // Direction held at push level through release so it never moves with SPC.
      P_REL:
        ctrl_d = '{nsk_en: 1'b1, sp_d_nu: DIR_PUSH, spc: 1'b0, store_oe: 1'b0};
      Q_SETUP, Q_SETTLE:
        ctrl_d = '{nsk_en: 1'b0, sp_d_nu: DIR_POP, spc: 1'b0, store_oe: 1'b0};
      Q_COUNT:
        ctrl_d = '{nsk_en: 1'b0, sp_d_nu: DIR_POP, spc: 1'b1, store_oe: 1'b0};
      Q_READ:
        ctrl_d = '{nsk_en: 1'b1, sp_d_nu: DIR_POP, spc: 1'b0, store_oe: 1'b0};
      default: busy_d = 1'b0;
    endcase
  end

  assign bus.BUSY     = busy_q;
  assign bus.DONE     = done_q;
  assign bus.DOUT     = dout_q;
  assign bus.OVF      = ovf_q;
  assign bus.UNF      = unf_q;
  assign bus.REQ_ERR  = req_err_q;
  assign bus.DEPTH    = depth;
  assign bus.nSK_EN   = ctrl_q.nsk_en;
  assign bus.SP_D_nU  = ctrl_q.sp_d_nu;
  assign bus.SPC      = ctrl_q.spc;
  assign bus.STORE_OE = ctrl_q.store_oe;
  assign bus.STORE_DO = store_do_q;

endmodule

// File: tb/tb_stack_sequencer.sv
// Testbench for stack_sequencer: emulates the stack block (pointer + RAM)
// and compares the DUT against a LIFO queue model of the stack contents.
module tb_stack_sequencer;

  localparam int DEPTH_MAX = 256;
  localparam int SETTLE    = 1;
  localparam int MAX_TR    = 20;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stack_sequencer_if bus ();

  stack_sequencer #(
    .DEPTH_MAX  (DEPTH_MAX),
    .SETTLE_CYC (SETTLE)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  // Stack block emulation: pointer advances on SPC rising edges, RAM written
  // while the store bus is driven ahead of the count.
  logic [3:0] mem [256] = '{default: 4'h0};
  logic [7:0] sp        = 8'd0;
  logic       spc_prev  = 1'b0;
  logic       dir_prev  = 1'b1;
  int         spc_high  = 0;
  int         dir_glitch = 0;

  assign bus.STORE_DI = mem[sp];

  always @(negedge clk) begin
    if (bus.SPC === 1'b1) begin
      spc_high = spc_high + 1;
      if (spc_prev !== 1'b1) begin
        if (bus.SP_D_nU !== dir_prev) dir_glitch = dir_glitch + 1;
        if (bus.nSK_EN === 1'b0) sp = (bus.SP_D_nU === 1'b1) ? sp - 8'd1 : sp + 8'd1;
      end
    end else if (bus.STORE_OE === 1'b1 && bus.nSK_EN === 1'b0 && bus.SP_D_nU === 1'b0) begin
      mem[sp] = bus.STORE_DO;
    end
    spc_prev = bus.SPC;
    dir_prev = bus.SP_D_nU;
  end

  int checks = 0;
  int errors = 0;

  logic [3:0] model [$];
  logic [3:0] exp_dout = 4'h0;

  logic       tr_spc [1:MAX_TR];
  logic       tr_oe  [1:MAX_TR];
  logic       tr_dir [1:MAX_TR];
  logic       tr_nen [1:MAX_TR];
  logic [3:0] tr_do  [1:MAX_TR];
  int         busy_cnt;
  int         spc_delta;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one request (called in a BUSY=0 cycle) and trace until DONE.
  // poke>0 pulses PUSH_REQ during that busy cycle to exercise request dropping.
  task automatic run_req(input bit p, input bit q, input logic [3:0] d,
                         input int poke, output int lat);
    int spc0;
    lat      = 0;
    busy_cnt = 0;
    spc0     = spc_high;
    bus.PUSH_REQ = p;
    bus.POP_REQ  = q;
    bus.DIN      = d;
    @(posedge clk); #1;
    bus.PUSH_REQ = 1'b0;
    bus.POP_REQ  = 1'b0;
    bus.DIN      = ~d;
    for (int k = 1; k <= MAX_TR; k++) begin
      tr_spc[k] = bus.SPC;
      tr_oe[k]  = bus.STORE_OE;
      tr_dir[k] = bus.SP_D_nU;
      tr_nen[k] = bus.nSK_EN;
      tr_do[k]  = bus.STORE_DO;
      if (bus.DONE === 1'b1) begin
        lat = k;
        break;
      end
      if (bus.BUSY === 1'b1) busy_cnt++;
      if (k == poke) bus.PUSH_REQ = 1'b1;
      @(posedge clk); #1;
      bus.PUSH_REQ = 1'b0;
    end
    spc_delta = spc_high - spc0;
  endtask

  // Model-predicted request, then compare every observable at DONE.
  task automatic do_op(input bit p, input bit q, input logic [3:0] d, input int poke);
    int e_lat, e_spc, lat;
    bit e_ovf, e_unf, e_err;
    e_ovf = 0; e_unf = 0; e_err = 0; e_spc = 0; e_lat = 1;
    if (p && q) begin
      e_err = 1;
    end else if (p) begin
      if (model.size() >= DEPTH_MAX) e_ovf = 1;
      else begin
        model.push_back(d);
        e_lat = 5;
        e_spc = 1;
      end
    end else begin
      if (model.size() == 0) e_unf = 1;
      else begin
        exp_dout = model.pop_back();
        e_lat = 4 + SETTLE;
        e_spc = 1;
      end
    end
    run_req(p, q, d, poke, lat);
    check("latency", lat, e_lat);
    check("ovf", bus.OVF, e_ovf);
    check("unf", bus.UNF, e_unf);
    check("req_err", bus.REQ_ERR, e_err);
    check("busy_cycles", busy_cnt, e_lat - 1);
    check("busy_at_done", bus.BUSY, 1'b0);
    check("spc_cycles", spc_delta, e_spc);
    check("depth", bus.DEPTH, model.size());
    check("dout", bus.DOUT, exp_dout);
  endtask

  initial begin
    int r;
    bus.PUSH_REQ = 1'b0;
    bus.POP_REQ  = 1'b0;
    bus.DIN      = 4'h0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", bus.BUSY, 1'b0);
    check("rst_done", bus.DONE, 1'b0);
    check("rst_ovf", bus.OVF, 1'b0);
    check("rst_unf", bus.UNF, 1'b0);
    check("rst_req_err", bus.REQ_ERR, 1'b0);
    check("rst_dout", bus.DOUT, 4'h0);
    check("rst_depth", bus.DEPTH, 9'd0);
    check("rst_nsk_en", bus.nSK_EN, 1'b1);
    check("rst_sp_d_nu", bus.SP_D_nU, 1'b1);
    check("rst_spc", bus.SPC, 1'b0);
    check("rst_store_oe", bus.STORE_OE, 1'b0);
    check("rst_store_do", bus.STORE_DO, 4'h0);
    rst = 1'b0;

    // Push 0xA with cycle-accurate trace checks.
    do_op(1, 0, 4'hA, 0);
    for (int k = 1; k <= 3; k++) begin
      check($sformatf("push_oe_c%0d", k), tr_oe[k], 1'b1);
      check($sformatf("push_do_c%0d", k), tr_do[k], 4'hA);
      check($sformatf("push_nen_c%0d", k), tr_nen[k], 1'b0);
    end
    check("push_oe_c4", tr_oe[4], 1'b0);
    check("push_nen_c4", tr_nen[4], 1'b1);
    for (int k = 1; k <= 5; k++) begin
      check($sformatf("push_spc_c%0d", k), tr_spc[k], (k == 3) ? 1'b1 : 1'b0);
      check($sformatf("push_dir_c%0d", k), tr_dir[k], (k == 5) ? 1'b1 : 1'b0);
    end

    // Push 0x3, pop it back, then pop 0xA.
    do_op(1, 0, 4'h3, 0);
    do_op(0, 1, 4'h0, 0);
    for (int k = 1; k <= 5; k++) begin
      check($sformatf("pop_spc_c%0d", k), tr_spc[k], (k == 2) ? 1'b1 : 1'b0);
      check($sformatf("pop_dir_c%0d", k), tr_dir[k], 1'b1);
    end
    check("pop_nen_c4", tr_nen[4], 1'b1);
    do_op(0, 1, 4'h0, 0);

    // Underflow at empty.
    do_op(0, 1, 4'h0, 0);
    check("unf_nen_c1", tr_nen[1], 1'b1);

    // Conflicting request.
    do_op(1, 1, 4'h7, 0);

    // Push with a second PUSH_REQ pulsed while busy.
    do_op(1, 0, 4'hC, 2);

    // Randomized mix against the model.
    for (int i = 0; i < 150; i++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)      do_op(1, 1, 4'($urandom), 0);
      else if (r <= 5) do_op(1, 0, 4'($urandom), int'($urandom_range(0, 3)));
      else             do_op(0, 1, 4'($urandom), int'($urandom_range(0, 3)));
    end

    // Fill to capacity, then overflow.
    while (model.size() < DEPTH_MAX) do_op(1, 0, 4'($urandom), 0);
    do_op(1, 0, 4'h9, 0);
    check("ovf_nen_c1", tr_nen[1], 1'b1);
    repeat (3) do_op(0, 1, 4'h0, 0);
    while (model.size() < DEPTH_MAX) do_op(1, 0, 4'($urandom), 0);

    // Reset at full returns occupancy to zero.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model.delete();
    exp_dout = 4'h0;
    check("full_rst_depth", bus.DEPTH, 9'd0);
    check("full_rst_dout", bus.DOUT, 4'h0);

    // Reset in P_COUNT of a push aborts without DONE.
    bus.PUSH_REQ = 1'b1;
    bus.DIN      = 4'h6;
    @(posedge clk); #1;
    bus.PUSH_REQ = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("mid_spc_in_count", bus.SPC, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_nsk_en", bus.nSK_EN, 1'b1);
    check("mid_spc", bus.SPC, 1'b0);
    check("mid_store_oe", bus.STORE_OE, 1'b0);
    check("mid_depth", bus.DEPTH, 9'd0);
    check("mid_done", bus.DONE, 1'b0);
    check("mid_busy", bus.BUSY, 1'b0);
    do_op(1, 0, 4'h5, 0);
    do_op(0, 1, 4'h0, 0);

    check("spc_dir_glitch", dir_glitch, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
